// File: rtl/psychic5_video_timing.sv
// Psychic 5 raster timing: pixel-enable divider, H/V counters, registered syncs/blanks,
// with per-frame latching of refresh-mode, vertical-position and flip settings.
module psychic5_video_timing #(
    parameter int unsigned PXDIV       = 10,
    parameter int unsigned HVIS        = 256,
    parameter int unsigned HTOTAL0     = 384,
    parameter int unsigned VTOTAL0     = 264,
    parameter int unsigned VTOTAL_NTSC = 262,
    parameter int unsigned HS_START    = 288,
    parameter int unsigned HS_END      = 319,
    parameter int unsigned VVIS_START  = 16,
    parameter int unsigned VVIS_END    = 239,
    parameter int unsigned VS_BASE     = 248
) (
    input  logic       i_EMU_MCLK,
    input  logic       i_EMU_RST_n,
    input  logic       i_EMU_FLIP,
    input  logic [3:0] i_EMU_VPOS_ADJ,
    input  logic [1:0] i_EMU_PXCNTR_ADJ_MODE,
    input  logic [1:0] i_EMU_PXCNTR_ADJ_H,
    input  logic [2:0] i_EMU_PXCNTR_ADJ_V,
    output logic       o_PXCEN,
    output logic [8:0] o_HCOUNT,
    output logic [8:0] o_VCOUNT,
    output logic       o_HSYNC_n,
    output logic       o_VSYNC_n,
    output logic       o_HBLANK_n,
    output logic       o_VBLANK_n,
    output logic       o_FLIP,
    output logic       o_FRAME_START
);

    localparam int unsigned DIVW = (PXDIV > 1) ? $clog2(PXDIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(PXDIV - 1);

    localparam logic [8:0] HVIS_W     = 9'(HVIS);
    localparam logic [8:0] HTOT0_W    = 9'(HTOTAL0);
    localparam logic [8:0] VTOT0_W    = 9'(VTOTAL0);
    localparam logic [8:0] VNTSC_W    = 9'(VTOTAL_NTSC);
    localparam logic [8:0] HS_START_W = 9'(HS_START);
    localparam logic [8:0] HS_END_W   = 9'(HS_END);
    localparam logic [8:0] VVS_W      = 9'(VVIS_START);
    localparam logic [8:0] VVE_W      = 9'(VVIS_END);
    localparam logic [8:0] VS_BASE_W  = 9'(VS_BASE);

    logic [DIVW-1:0] div_q, div_d;
    logic [8:0]      hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [8:0]      htot_q, htot_d, vtot_q, vtot_d;
    logic [8:0]      vs_start_q, vs_start_d;
    logic            pxcen_q, pxcen_d, fs_q, fs_d, flip_q, flip_d;
    logic            hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
    logic            hblank_n_q, hblank_n_d, vblank_n_q, vblank_n_d;

    logic       px_edge, line_end, frame_end;
    logic [8:0] htot_sel, vtot_sel, vs_sel;

    // Candidate timing from the OSD inputs; only taken at a frame boundary.
    always_comb begin
        htot_sel = HTOT0_W;
        vtot_sel = VTOT0_W;
        case (i_EMU_PXCNTR_ADJ_MODE)
            2'd1: vtot_sel = VNTSC_W;
            2'd2: begin
                htot_sel = HTOT0_W + {6'd0, i_EMU_PXCNTR_ADJ_H, 1'b0};
                vtot_sel = VNTSC_W + {6'd0, i_EMU_PXCNTR_ADJ_V};
            end
            default: ;
        endcase
        // vsync start = base + (adj - 8); adj 0 keeps the original position
        vs_sel = (i_EMU_VPOS_ADJ == 4'd0) ? VS_BASE_W
                                          : VS_BASE_W - 9'd8 + {5'd0, i_EMU_VPOS_ADJ};
    end

    always_comb begin
        px_edge   = (div_q == DIV_LAST);
        line_end  = (hcnt_q == htot_q - 9'd1);
        frame_end = line_end && (vcnt_q == vtot_q - 9'd1);

        div_d      = px_edge ? '0 : div_q + 1'b1;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        htot_d     = htot_q;
        vtot_d     = vtot_q;
        vs_start_d = vs_start_q;
        flip_d     = flip_q;
        pxcen_d    = 1'b0;
        fs_d       = 1'b0;
        hsync_n_d  = hsync_n_q;
        vsync_n_d  = vsync_n_q;
        hblank_n_d = hblank_n_q;
        vblank_n_d = vblank_n_q;

        if (px_edge) begin
            pxcen_d = 1'b1;
            hcnt_d  = line_end ? '0 : hcnt_q + 9'd1;
            if (line_end)
                vcnt_d = frame_end ? '0 : vcnt_q + 9'd1;
            if (frame_end) begin
                htot_d     = htot_sel;
                vtot_d     = vtot_sel;
                vs_start_d = vs_sel;
                flip_d     = i_EMU_FLIP;
                fs_d       = 1'b1;
            end
            hblank_n_d = (hcnt_d < HVIS_W);
            hsync_n_d  = !((hcnt_d >= HS_START_W) && (hcnt_d <= HS_END_W));
            vblank_n_d = (vcnt_d >= VVS_W) && (vcnt_d <= VVE_W);
            vsync_n_d  = !((vcnt_d >= vs_start_d) && (vcnt_d <= vs_start_d + 9'd2));
        end
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
        if (!i_EMU_RST_n) begin
            div_q      <= '0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            htot_q     <= HTOT0_W;
            vtot_q     <= VTOT0_W;
            vs_start_q <= VS_BASE_W;
            flip_q     <= 1'b0;
            pxcen_q    <= 1'b0;
            fs_q       <= 1'b0;
            hsync_n_q  <= 1'b1;
            vsync_n_q  <= 1'b1;
            hblank_n_q <= 1'b0;
            vblank_n_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            htot_q     <= htot_d;
            vtot_q     <= vtot_d;
            vs_start_q <= vs_start_d;
            flip_q     <= flip_d;
            pxcen_q    <= pxcen_d;
            fs_q       <= fs_d;
            hsync_n_q  <= hsync_n_d;
            vsync_n_q  <= vsync_n_d;
            hblank_n_q <= hblank_n_d;
            vblank_n_q <= vblank_n_d;
        end
    end

    assign o_PXCEN       = pxcen_q;
    assign o_HCOUNT      = hcnt_q;
    assign o_VCOUNT      = vcnt_q;
    assign o_HSYNC_n     = hsync_n_q;
    assign o_VSYNC_n     = vsync_n_q;
    assign o_HBLANK_n    = hblank_n_q;
    assign o_VBLANK_n    = vblank_n_q;
    assign o_FLIP        = flip_q;
    assign o_FRAME_START = fs_q;

endmodule
